// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock IO command/response port among several requesters.
// An order FIFO of grants routes the in-order responses back to the requester that issued each command.
module bp_io_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 8,
    parameter int max_outstanding_p = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0]          req_cmd_i,
    input  logic [num_req_p-1:0]                      req_cmd_v_i,
    output logic [num_req_p-1:0]                      req_cmd_yumi_o,
    output logic [msg_width_p-1:0]                    req_resp_o,
    output logic [num_req_p-1:0]                      req_resp_v_o,
    input  logic [num_req_p-1:0]                      req_resp_ready_and_i,
    output logic [msg_width_p-1:0]                    cmd_o,
    output logic                                      cmd_v_o,
    input  logic                                      cmd_ready_and_i,
    input  logic [msg_width_p-1:0]                    resp_i,
    input  logic                                      resp_v_i,
    output logic                                      resp_yumi_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]    outstanding_o,
    output logic                                      err_o
);
    localparam int gnt_w = $clog2(num_req_p);
    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(max_outstanding_p);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(max_outstanding_p - 1);

    typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_e;

    lock_e            lock_q;
    logic [gnt_w-1:0] locked_g_q;
    logic [gnt_w-1:0] rr_last_q;
    logic [gnt_w-1:0] rr_g;
    logic [gnt_w-1:0] cand_g;
    logic [gnt_w-1:0] g;
    logic [gnt_w-1:0] h;
    logic [cnt_w-1:0] count_q;
    logic [ptr_w-1:0] rd_ptr_q;
    logic [ptr_w-1:0] wr_ptr_q;
    logic [gnt_w-1:0] order_mem [max_outstanding_p];
    logic             err_q;
    logic             found;
    logic             has_out;
    logic             push;
    logic             pop;

    // Scan starts just after the last served requester so every requester gets a turn.
    always_comb begin
        rr_g   = rr_last_q;
        cand_g = rr_last_q;
        found  = 1'b0;
        for (int unsigned i = 1; i <= num_req_p; i++) begin
            cand_g = gnt_w'((32'(rr_last_q) + i) % num_req_p);
            if (!found && req_cmd_v_i[cand_g]) begin
                rr_g  = cand_g;
                found = 1'b1;
            end
        end
    end

    assign g       = (lock_q == LOCK_HELD) ? locked_g_q : rr_g;
    assign cmd_o   = req_cmd_i[32'(g)*msg_width_p +: msg_width_p];
    assign cmd_v_o = reset_n_i & req_cmd_v_i[g] & (count_q < cnt_max);
    assign push    = cmd_v_o & cmd_ready_and_i;

    assign has_out     = (count_q != '0);
    assign h           = order_mem[rd_ptr_q];
    assign resp_yumi_o = reset_n_i & resp_v_i & has_out & req_resp_ready_and_i[h];
    assign pop         = resp_yumi_o;
    assign req_resp_o  = resp_i;

    always_comb begin
        req_cmd_yumi_o = '0;
        req_resp_v_o   = '0;
        if (push)
            req_cmd_yumi_o[g] = 1'b1;
        if (reset_n_i && has_out)
            req_resp_v_o[h] = resp_v_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_q     <= LOCK_IDLE;
            locked_g_q <= '0;
            rr_last_q  <= gnt_w'(num_req_p - 1);
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                lock_q    <= LOCK_IDLE;
                rr_last_q <= g;
                wr_ptr_q  <= (wr_ptr_q == ptr_last) ? '0 : wr_ptr_q + ptr_w'(1);
            end else if (cmd_v_o) begin
                lock_q     <= LOCK_HELD;
                locked_g_q <= g;
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == ptr_last) ? '0 : rd_ptr_q + ptr_w'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + cnt_w'(1);
                2'b01:   count_q <= count_q - cnt_w'(1);
                default: count_q <= count_q;
            endcase
            if (resp_v_i && !has_out)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            order_mem[wr_ptr_q] <= g;
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule
